// File: rtl/timer_irq_periph_pkg.sv
// Shared constants for the timer/IRQ peripheral: register offsets, TCON bit
// positions and the default window base. Optional prescaler: TIMER_PRESCALE_EN.
package timer_irq_periph_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_LED     = 5'h0C;
   localparam logic [4:0] OFF_SWITCH  = 5'h10;
   localparam logic [4:0] OFF_DIGI    = 5'h14;
   localparam logic [4:0] OFF_SYSTICK = 5'h18;
   localparam logic [4:0] OFF_PRESC   = 5'h1C;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

endpackage

// File: rtl/periph_timer_core.sv
// Reloadable 32-bit timer: TH/TL/TCON, overflow reload and interrupt status.
// With TIMER_PRESCALE_EN defined, TL advances only when the prescale counter matches PRESC.
module periph_timer_core
   import timer_irq_periph_pkg::*;
#(
   parameter int TCON_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              th_we,
   input  logic              tl_we,
   input  logic              tcon_we,
`ifdef TIMER_PRESCALE_EN
   input  logic              presc_we,
   output logic [15:0]       presc,
`endif
   input  logic [31:0]       wdata,
   output logic [31:0]       th,
   output logic [31:0]       tl,
   output logic [TCON_W-1:0] tcon,
   output logic              irq
);

   logic en_now;
   logic ie_now;
   logic tick;
   logic ovf;

`ifdef TIMER_PRESCALE_EN
   logic [15:0] presc_cnt;
`endif

   // A TCON write governs this very edge: disabling stops TL now, and an
   // irq-enable written alongside an overflow still latches the status.
   always_comb begin
      en_now = tcon_we ? wdata[TCON_EN] : tcon[TCON_EN];
      ie_now = tcon_we ? wdata[TCON_IE] : tcon[TCON_IE];
`ifdef TIMER_PRESCALE_EN
      tick   = en_now & (presc_cnt == presc);
`else
      tick   = en_now;
`endif
      ovf    = tick & (tl == 32'hFFFF_FFFF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (th_we) th <= wdata;

         if (tl_we)     tl <= wdata;
         else if (ovf)  tl <= th;
         else if (tick) tl <= tl + 32'd1;

         if (tcon_we)         tcon <= wdata[TCON_W-1:0];
         if (ovf && ie_now)   tcon[TCON_IS] <= 1'b1;
      end
   end

`ifdef TIMER_PRESCALE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc     <= '0;
         presc_cnt <= '0;
      end else begin
         if (presc_we) presc <= wdata[15:0];

         if (presc_we)    presc_cnt <= '0;
         else if (en_now) presc_cnt <= (presc_cnt == presc) ? 16'd0 : presc_cnt + 16'd1;
      end
   end
`endif

   assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/timer_irq_periph.sv
// Memory-mapped timer/LED/switch/7-segment/systick peripheral driving IRQ.
// Optional PRESC register at 0x1C when TIMER_PRESCALE_EN is defined.
module timer_irq_periph
   import timer_irq_periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          TCON_W    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   input  logic [7:0]  switch,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        IRQ
);

   logic              hit;
   logic [4:0]        off;
   logic              wr_en;
   logic              th_we, tl_we, tcon_we, led_we, digi_we;
   logic [31:0]       th, tl, systick;
   logic [TCON_W-1:0] tcon;
`ifdef TIMER_PRESCALE_EN
   logic              presc_we;
   logic [15:0]       presc;
`endif

   assign hit   = (Addr[31:5] == BASE_ADDR[31:5]);
   assign off   = Addr[4:0];
   assign wr_en = MemWr & hit;

   assign th_we   = wr_en & (off == OFF_TH);
   assign tl_we   = wr_en & (off == OFF_TL);
   assign tcon_we = wr_en & (off == OFF_TCON);
   assign led_we  = wr_en & (off == OFF_LED);
   assign digi_we = wr_en & (off == OFF_DIGI);
`ifdef TIMER_PRESCALE_EN
   assign presc_we = wr_en & (off == OFF_PRESC);
`endif

   periph_timer_core #(
      .TCON_W (TCON_W)
   ) u_timer_core (
      .clk      (clk),
      .reset    (reset),
      .th_we    (th_we),
      .tl_we    (tl_we),
      .tcon_we  (tcon_we),
`ifdef TIMER_PRESCALE_EN
      .presc_we (presc_we),
      .presc    (presc),
`endif
      .wdata    (WriteData),
      .th       (th),
      .tl       (tl),
      .tcon     (tcon),
      .irq      (IRQ)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led     <= '0;
         digi    <= '0;
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
         if (led_we)  led  <= WriteData[7:0];
         if (digi_we) digi <= WriteData[11:0];
      end
   end

   // Loads only see data while MemRd is high and the window is hit.
   always_comb begin
      ReadData = '0;
      if (MemRd && hit) begin
         case (off)
            OFF_TH:      ReadData = th;
            OFF_TL:      ReadData = tl;
            OFF_TCON:    ReadData = {{(32-TCON_W){1'b0}}, tcon};
            OFF_LED:     ReadData = {24'd0, led};
            OFF_SWITCH:  ReadData = {24'd0, switch};
            OFF_DIGI:    ReadData = {20'd0, digi};
            OFF_SYSTICK: ReadData = systick;
`ifdef TIMER_PRESCALE_EN
            OFF_PRESC:   ReadData = {16'd0, presc};
`endif
            default:     ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_irq_periph.sv
// Self-checking bench for timer_irq_periph: directed scenarios plus randomized
// bus traffic against a register-level reference model.
module tb_timer_irq_periph;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRd, MemWr;
   logic [31:0] Addr, WriteData, ReadData;
   logic [7:0]  switch, led;
   logic [11:0] digi;
   logic        IRQ;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] m_th, m_tl, m_sys;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led;
   logic [11:0] m_digi;
   logic [15:0] m_presc, m_pcnt;

   timer_irq_periph dut (
      .clk       (clk),
      .reset     (reset),
      .MemRd     (MemRd),
      .MemWr     (MemWr),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .switch    (switch),
      .led       (led),
      .digi      (digi),
      .IRQ       (IRQ)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_th = '0; m_tl = '0; m_sys = '0; m_tcon = '0;
      m_led = '0; m_digi = '0; m_presc = '0; m_pcnt = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:5] != BASE[31:5]) return 32'd0;
      case (a[4:0])
         5'h00: return m_th;
         5'h04: return m_tl;
         5'h08: return {29'd0, m_tcon};
         5'h0C: return {24'd0, m_led};
         5'h10: return {24'd0, switch};
         5'h14: return {20'd0, m_digi};
         5'h18: return m_sys;
`ifdef TIMER_PRESCALE_EN
         5'h1C: return {16'd0, m_presc};
`endif
         default: return 32'd0;
      endcase
   endfunction

   // One clock: the model applies the register-map rules to the inputs held
   // across the coming rising edge, then the bench returns at the falling edge.
   task automatic step();
      logic hit, w_th, w_tl, w_tcon, w_led, w_digi;
      logic en, ie, adv, ovf;
      logic [31:0] n_tl;
      logic [2:0]  n_tcon;
`ifdef TIMER_PRESCALE_EN
      logic w_presc;
`endif
      hit    = MemWr && (Addr[31:5] == BASE[31:5]);
      w_th   = hit && Addr[4:0] == 5'h00;
      w_tl   = hit && Addr[4:0] == 5'h04;
      w_tcon = hit && Addr[4:0] == 5'h08;
      w_led  = hit && Addr[4:0] == 5'h0C;
      w_digi = hit && Addr[4:0] == 5'h14;
      en = w_tcon ? WriteData[0] : m_tcon[0];
      ie = w_tcon ? WriteData[1] : m_tcon[1];
      adv = en;
`ifdef TIMER_PRESCALE_EN
      w_presc = hit && Addr[4:0] == 5'h1C;
      adv = en && (m_pcnt == m_presc);
`endif
      ovf = adv && (m_tl == 32'hFFFF_FFFF);
      if (w_tl)     n_tl = WriteData;
      else if (ovf) n_tl = m_th;
      else if (adv) n_tl = m_tl + 1;
      else          n_tl = m_tl;
      n_tcon = w_tcon ? WriteData[2:0] : m_tcon;
      if (ovf && ie) n_tcon[2] = 1'b1;
      @(posedge clk);
      if (w_th)   m_th   = WriteData;
      if (w_led)  m_led  = WriteData[7:0];
      if (w_digi) m_digi = WriteData[11:0];
`ifdef TIMER_PRESCALE_EN
      if (w_presc) begin
         m_presc = WriteData[15:0];
         m_pcnt  = 16'd0;
      end else if (en) begin
         m_pcnt = (m_pcnt == m_presc) ? 16'd0 : m_pcnt + 16'd1;
      end
`endif
      m_tl   = n_tl;
      m_tcon = n_tcon;
      m_sys  = m_sys + 1;
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      MemWr = 1'b1; Addr = a; WriteData = d;
      step();
      MemWr = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
      MemRd = 1'b1; Addr = a;
      #1;
      d = ReadData;
      MemRd = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
      n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL rst_led got=%h exp=00", led); end
      n_tests++; if (digi !== 12'h000) begin n_fail++; $display("FAIL rst_digi got=%h exp=000", digi); end
      read_reg(BASE + 32'h18, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_systick got=%h exp=0", rd); end
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_tcon got=%h exp=0", rd); end
      // mid-run async reset
      bus_write(BASE + 32'h0C, 32'h5A);
      bus_write(BASE + 32'h04, 32'd5);
      bus_write(BASE + 32'h08, 32'h7);
      steps(2);
      n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL prerst_irq got=%b exp=1", IRQ); end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL async_irq got=%b exp=0", IRQ); end
      n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL async_led got=%h exp=00", led); end
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL async_tl got=%h exp=0", rd); end
      read_reg(BASE + 32'h18, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL async_systick got=%h exp=0", rd); end
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL async_tcon got=%h exp=0", rd); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      steps(3);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_tl_idle got=%h exp=0", rd); end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bus_write(BASE + 32'h00, 32'hFFFF_FFF0);
      bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h08, 32'h3);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf_tl1 got=%h exp=ffffffff", rd); end
      step();
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL ovf_reload got=%h exp=fffffff0", rd); end
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'h7) begin n_fail++; $display("FAIL ovf_tcon got=%h exp=7", rd); end
      n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got=%b exp=1", IRQ); end
      steps(15);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf_tl15 got=%h exp=ffffffff", rd); end
      step();
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL ovf_reload2 got=%h exp=fffffff0", rd); end
   endtask

   task automatic test_irq_disabled();
      logic [31:0] rd;
      bus_write(BASE + 32'h08, 32'h0);
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL dis_irqclr got=%b exp=0", IRQ); end
      bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h08, 32'h1);
      step();
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL dis_reload got=%h exp=fffffff0", rd); end
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL dis_tcon got=%h exp=1", rd); end
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL dis_irq got=%b exp=0", IRQ); end
   endtask

   task automatic test_race();
      logic [31:0] rd;
      // clear lands on the overflow edge: set wins
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h08, 32'h7);
      bus_write(BASE + 32'h08, 32'h3);
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'h7) begin n_fail++; $display("FAIL race_tcon got=%h exp=7", rd); end
      n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL race_irq got=%b exp=1", IRQ); end
      // clear one cycle early: IRQ drops, then rises on overflow
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
      bus_write(BASE + 32'h08, 32'h7);
      bus_write(BASE + 32'h08, 32'h3);
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL early_irq_low got=%b exp=0", IRQ); end
      step();
      n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL early_irq_high got=%b exp=1", IRQ); end
      // CPU write to TL on the overflow edge wins over reload
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_write(BASE + 32'h08, 32'h3);
      bus_write(BASE + 32'h04, 32'h0000_1234);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL tlwr_tl got=%h exp=00001234", rd); end
      read_reg(BASE + 32'h08, rd);
      n_tests++; if (rd !== 32'h7) begin n_fail++; $display("FAIL tlwr_tcon got=%h exp=7", rd); end
      // disabling takes effect on the writing edge
      bus_write(BASE + 32'h08, 32'h1);
      bus_write(BASE + 32'h04, 32'd100);
      step();
      bus_write(BASE + 32'h08, 32'h0);
      step();
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd101) begin n_fail++; $display("FAIL disable_tl got=%0d exp=101", rd); end
   endtask

   task automatic test_bus_map();
      logic [31:0] rd;
      bus_write(BASE + 32'h0C, 32'hFFFF_FFA5);
      n_tests++; if (led !== 8'hA5) begin n_fail++; $display("FAIL map_led got=%h exp=a5", led); end
      bus_write(32'h3000_000C, 32'h0000_00FF);
      n_tests++; if (led !== 8'hA5) begin n_fail++; $display("FAIL map_led_miss got=%h exp=a5", led); end
      switch = 8'h3C;
      read_reg(BASE + 32'h10, rd);
      n_tests++; if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL map_switch got=%h exp=0000003c", rd); end
      bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
      bus_write(BASE + 32'h18, 32'hDEAD_BEEF);
      read_reg(BASE + 32'h10, rd);
      n_tests++; if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL map_switch_ro got=%h exp=0000003c", rd); end
      read_reg(BASE + 32'h18, rd);
      n_tests++; if (rd !== m_sys) begin n_fail++; $display("FAIL map_systick_ro got=%h exp=%h", rd, m_sys); end
      bus_write(BASE + 32'h14, 32'hFFFF_FABC);
      n_tests++; if (digi !== 12'hABC) begin n_fail++; $display("FAIL map_digi got=%h exp=abc", digi); end
      read_reg(BASE + 32'h14, rd);
      n_tests++; if (rd !== 32'h0000_0ABC) begin n_fail++; $display("FAIL map_digi_rd got=%h exp=00000abc", rd); end
      read_reg(BASE + 32'h20, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL map_outside got=%h exp=0", rd); end
      read_reg(32'h3000_0000, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL map_other got=%h exp=0", rd); end
      MemRd = 1'b0; Addr = BASE + 32'h0C;
      #1;
      n_tests++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL map_nord got=%h exp=0", ReadData); end
`ifndef TIMER_PRESCALE_EN
      bus_write(BASE + 32'h1C, 32'h1234_5678);
      read_reg(BASE + 32'h1C, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL map_1c got=%h exp=0", rd); end
`endif
   endtask

`ifdef TIMER_PRESCALE_EN
   task automatic test_prescale();
      logic [31:0] rd;
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h1C, 32'h3);
      bus_write(BASE + 32'h04, 32'h0);
      bus_write(BASE + 32'h08, 32'h1);
      steps(3);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL presc_tl1 got=%0d exp=1", rd); end
      steps(3);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL presc_hold got=%0d exp=1", rd); end
      step();
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd2) begin n_fail++; $display("FAIL presc_tl2 got=%0d exp=2", rd); end
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h1C, 32'h0);
      bus_write(BASE + 32'h04, 32'h0);
      bus_write(BASE + 32'h08, 32'h1);
      steps(4);
      read_reg(BASE + 32'h04, rd);
      n_tests++; if (rd !== 32'd5) begin n_fail++; $display("FAIL presc0_tl got=%0d exp=5", rd); end
   endtask
`endif

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return BASE + 32'(r * 4);
      if (r == 8) return BASE + 32'h20;
      return 32'h3000_0000 + 32'($urandom_range(0, 7) * 4);
   endfunction

   task automatic test_random();
      logic [31:0] a, rd, exp, wd;
      for (int i = 0; i < 600; i++) begin
         switch = 8'($urandom);
         a = pick_addr();
         read_reg(a, rd);
         exp = model_read(a);
         n_tests++; if (rd !== exp) begin n_fail++; $display("FAIL rnd_read i=%0d addr=%h got=%h exp=%h", i, a, rd, exp); end
         n_tests++; if (IRQ !== (m_tcon[1] & m_tcon[2])) begin n_fail++; $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, IRQ, m_tcon[1] & m_tcon[2]); end
         n_tests++; if (led !== m_led || digi !== m_digi) begin n_fail++; $display("FAIL rnd_io i=%0d led=%h/%h digi=%h/%h", i, led, m_led, digi, m_digi); end
         if ($urandom_range(0, 2) == 0) begin
            a = pick_addr();
            if (a[4:0] == 5'h00 || a[4:0] == 5'h04)
               wd = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            else if (a[4:0] == 5'h1C)
               wd = {$urandom_range(0, 65535), 16'($urandom_range(0, 3))};
            else
               wd = $urandom;
            MemWr = 1'b1; MemRd = 1'($urandom_range(0, 1)); Addr = a; WriteData = wd;
            step();
            MemWr = 1'b0; MemRd = 1'b0;
         end else begin
            step();
         end
      end
   endtask

   initial begin
      reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0;
      Addr = '0; WriteData = '0; switch = 8'h00;
      model_reset();
      test_reset();
      test_overflow();
      test_irq_disabled();
      test_race();
      test_bus_map();
`ifdef TIMER_PRESCALE_EN
      test_prescale();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
